dm_bus: RTL and testbench
=========================

# dm_bus

Parametrised, pipelined data memory for the CPU datapath, sitting between the MEM stage and the word-addressed storage array. It accepts one byte-addressed load or store per cycle over a valid/ready request port and returns a response after a fixed, configurable latency. It supports byte, half and word accesses with sign or zero extension, and flags misaligned and out-of-range accesses. Memory zeroing is done by a per-word hardware sweep after reset or on request, not by a one-cycle clear.

## Interface
- ADDR_W, 10, word-address bits; the array holds 2^ADDR_W 32-bit words.
- LATENCY, 1, response latency in cycles; legal range 1..4.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  starts a zeroing sweep when sampled high in READY.
- busy  out  1  high while a sweep runs.
- req_valid  in  1  request present.
- req_ready  out  1  equals (state==READY) && !clear.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for stores and for word accesses.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low bits for sub-word stores.
- req_pc  in  32  PC of the instruction, used for the store trace.
- resp_valid  out  1  response present; there is no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size access.

## Operation
- Accept rule: a request is accepted on an edge where req_valid && req_ready.
- Word index is req_addr[ADDR_W+1:2].
- Byte order is little-endian: byte lane b is bits 8b+7:8b, with lane = addr[1:0].
- Error conditions (any one sets err):
  - req_addr[31:ADDR_W+2] != 0;
  - req_size==11;
  - half access with addr[0]==1;
  - word access with addr[1:0]!=0.
- An errored access has no side effect: nothing is written and rdata is 0.
- Store: on the acceptance edge, the selected lanes are merged into the stored word using byte enables.
  - The same edge executes the trace `$display("@%h: *%h <= %h", req_pc, req_addr, merged_word)`.
- Load: the array is read at the acceptance edge and the result is extracted and extended.
  - A load accepted one cycle after a store to the same word returns the new data.
- Every accepted request, load or store, produces exactly one response, in order.
- FSM has two states, CLEAR and READY.
  - CLEAR: writes zero to word[cnt] each cycle and increments cnt. When cnt reaches 2^ADDR_W-1, the state moves to READY with cnt=0. busy=1 throughout.
  - READY: clear=1 moves the state to CLEAR on the next edge with cnt=0.
  - clear is ignored while already in CLEAR.
- Requests accepted before a sweep starts still drain their responses during the sweep.

## Timing
- Reset state:
  - state=CLEAR, cnt=0, busy=1, req_ready=0;
  - all pipeline valid bits cleared;
  - resp_valid=0, resp_rdata=0, resp_err=0.
- After reset release, the array is zero after exactly 2^ADDR_W cycles (1024 at the default). req_ready first goes high in the cycle after the final sweep write.
- Asserting reset mid-sweep or mid-pipeline discards in-flight responses and restarts the sweep at cnt=0.
- Latency: for a request accepted at edge k, resp_valid is high in the cycle following edge k+LATENCY-1, for exactly one cycle per request.
- Throughput is one request per cycle in READY.
- If clear and req_valid are high in the same cycle, clear wins: req_ready=0 and the request is not accepted.

## Structure
- Package dm_pkg holds:
  - size constants SZ_B, SZ_H, SZ_W;
  - the state enum {CLEAR, READY};
  - the LATENCY bounds.
- One sub-module, dm_lane, is purely combinational and handles:
  - byte-enable generation;
  - store merge;
  - load lane extraction and extension;
  - alignment check.
- The top level holds the array, the sweep FSM, the latency shift pipeline and the trace.

## Test plan
- Reset release at ADDR_W=10 -> busy high for 1024 cycles, req_ready low throughout, then LW 0x0 -> rdata 0x00000000, err 0.
- SW 0x10 0x8899AABB, then:
  - LB 0x13 -> 0xFFFFFF88;
  - LBU 0x12 -> 0x00000099;
  - LH 0x10 -> 0xFFFFAABB;
  - LHU 0x12 -> 0x00008899.
- SW 0x20 0x11223344, SB 0x21 0xCC -> LW 0x20 = 0x1122CC44. Then SH 0x22 0x5566 -> 0x5566CC44. Each store prints a trace line with the merged word.
- LW 0x22, SH 0x23, LW 0x1000 and size 11 each -> resp_err=1 and rdata=0. The word at 0x20 is unchanged.
- LATENCY=3, eight back-to-back loads -> eight responses on consecutive cycles, in order, each 3 cycles after acceptance.
- In READY, clear and req_valid high together -> request not accepted and sweep runs. Reset asserted at cnt=500 -> sweep restarts at 0, and previously written words read 0 afterwards.

Source files
------------

// File: rtl/dm_bus_pkg.sv
// Shared constants and types for the dm_bus data memory.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/dm_bus_if.sv
// Request/response port between the MEM stage and the data memory.
interface dm_bus_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_bus_lane.sv
// Byte-lane logic: byte enables, store merge, load extraction/extension and
// alignment check for one access against one 32-bit word.
module dm_lane
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [3:0]  be_s;
  logic [31:0] wrep_s;
  logic [31:0] shifted_s;

  assign shifted_s = word >> {lane, 3'b000};

  // Byte enables, lane-replicated store data and alignment per access size
  always_comb begin
    be_s       = 4'b0000;
    wrep_s     = wdata;
    misaligned = 1'b1;
    case (size)
      SZ_B: begin
        be_s       = 4'b0001 << lane;
        wrep_s     = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      SZ_H: begin
        be_s       = lane[1] ? 4'b1100 : 4'b0011;
        wrep_s     = {2{wdata[15:0]}};
        misaligned = lane[0];
      end
      SZ_W: begin
        be_s       = 4'b1111;
        wrep_s     = wdata;
        misaligned = (lane != 2'b00);
      end
      default: begin
        be_s       = 4'b0000;
        wrep_s     = wdata;
        misaligned = 1'b1;
      end
    endcase
  end

  // Merge enabled lanes of the store data into the stored word
  always_comb begin
    merged = word;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be_s[b] ? wrep_s[8*b +: 8] : word[8*b +: 8];
    end
  end

  // Extract the addressed lane and extend it to 32 bits
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SZ_B: load_data = uns ? {24'h00_0000, shifted_s[7:0]}
                            : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_H: load_data = uns ? {16'h0000, shifted_s[15:0]}
                            : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_W: load_data = word;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_bus.sv
// Pipelined byte-addressed data memory with hardware zeroing sweep,
// fixed response latency and store trace.
module dm_bus
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  output logic     busy,
  dm_bus_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]        mem_r [DEPTH];
  state_t             state_r, state_nx_s;
  logic [ADDR_W-1:0]  cnt_r, cnt_nx_s;

  logic [ADDR_W-1:0]  idx_s;
  logic [31:0]        word_s, merged_s, load_s, rdata_s;
  logic               misal_s, range_err_s, err_s, accept_s;

  logic [LATENCY-1:0] pv_r;
  logic [LATENCY-1:0] pe_r;
  logic [31:0]        pd_r [LATENCY];

  assign idx_s       = bus.req_addr[ADDR_W+1:2];
  assign range_err_s = |(bus.req_addr >> (ADDR_W + 2));
  assign err_s       = range_err_s | misal_s;
  assign accept_s    = bus.req_valid & bus.req_ready;
  assign word_s      = mem_r[idx_s];
  assign rdata_s     = (bus.req_we | err_s) ? 32'h0000_0000 : load_s;

  dm_lane u_lane (
    .size       (bus.req_size),
    .lane       (bus.req_addr[1:0]),
    .uns        (bus.req_unsigned),
    .wdata      (bus.req_wdata),
    .word       (word_s),
    .merged     (merged_s),
    .load_data  (load_s),
    .misaligned (misal_s)
  );

  // Sweep FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Sweep FSM next state: walk every word once, then serve requests
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == ADDR_W'(DEPTH - 1)) begin
          state_nx_s = READY;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s   = cnt_r + ADDR_W'(1);
        end
      end
      READY: begin
        if (clear) begin
          state_nx_s = CLEAR;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = READY;
        end
      end
      default: begin
        state_nx_s = CLEAR;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Sweep FSM outputs; clear takes priority over a pending request
  always_comb begin
    busy          = (state_r == CLEAR);
    bus.req_ready = (state_r == READY) && !clear;
  end

  // Single write port: sweep zeros in CLEAR, merged stores in READY
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem_r[cnt_r] <= 32'h0000_0000;
    end else if (accept_s && bus.req_we && !err_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

`ifndef SYNTHESIS
  // Store trace on the accepting edge
  always_ff @(posedge clk) begin
    if (reset && accept_s && bus.req_we && !err_s) begin
      $display("@%h: *%h <= %h", bus.req_pc, bus.req_addr, merged_s);
    end
  end
`endif

  // Latency shift pipeline; stage 0 captures the response at acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd_r[i] <= 32'h0000_0000;
      end
    end else begin
      pv_r[0] <= accept_s;
      pe_r[0] <= accept_s & err_s;
      pd_r[0] <= accept_s ? rdata_s : 32'h0000_0000;
      for (int i = 1; i < LATENCY; i++) begin
        pv_r[i] <= pv_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign bus.resp_valid = pv_r[LATENCY-1];
  assign bus.resp_err   = pe_r[LATENCY-1];
  assign bus.resp_rdata = pd_r[LATENCY-1];

endmodule

// File: tb/tb_dm_bus.sv
// Scoreboard bench for dm_bus: the driver queues expected responses, a
// negedge monitor pops and compares data, error flag and arrival cycle.
module tb_dm_bus;
  import dm_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LAT    = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic busy;

  dm_bus_if bus_i ();

  dm_bus #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_i.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got rdata %h err %b with nothing outstanding",
                 bus_i.resp_rdata, bus_i.resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, bus_i.resp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, 32'(bus_i.resp_err), 32'(mon_e.err));
        check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    @(negedge clk);
    bus_i.req_valid    = 1'b1;
    bus_i.req_we       = we;
    bus_i.req_size     = size;
    bus_i.req_unsigned = uns;
    bus_i.req_addr     = addr;
    bus_i.req_wdata    = wdata;
    bus_i.req_pc       = 32'h0000_1000 + (cyc << 2);
    #1;
    check({name, "_ready"}, 32'(bus_i.req_ready), 32'd1);
    if (bus_i.req_ready === 1'b1) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + LAT;
      e.name  = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus_i.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic sweep_wait(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (busy !== 1'b1 || bus_i.req_ready !== 1'b0) bad++;
    end
    check({name, "_busy_cycles_bad"}, 32'(bad), 32'd0);
    @(negedge clk);
    #1;
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_ready_end"}, 32'(bus_i.req_ready), 32'd1);
  endtask

  initial begin
    reset              = 1'b0;
    clear              = 1'b0;
    bus_i.req_valid    = 1'b0;
    bus_i.req_we       = 1'b0;
    bus_i.req_size     = SZ_W;
    bus_i.req_unsigned = 1'b0;
    bus_i.req_addr     = 32'h0;
    bus_i.req_wdata    = 32'h0;
    bus_i.req_pc       = 32'h0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(bus_i.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus_i.resp_valid), 32'd0);
    check("rst_resp_rdata", bus_i.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus_i.resp_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sweep_wait("init_sweep");

    issue("lw_0", 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
    issue("sw_10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h8899_AABB, 32'h0, 1'b0);
    issue("lb_13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0);
    issue("lbu_12", 1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 32'h0000_0099, 1'b0);
    issue("lh_10", 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFF_AABB, 1'b0);
    issue("lhu_12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000_8899, 1'b0);

    issue("sw_20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    issue("sb_21", 1'b1, SZ_B, 1'b0, 32'h21, 32'hFFFF_FFCC, 32'h0, 1'b0);
    issue("lw_20_a", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h1122_CC44, 1'b0);
    issue("sh_22", 1'b1, SZ_H, 1'b0, 32'h22, 32'hABCD_5566, 32'h0, 1'b0);
    issue("lw_20_b", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h5566_CC44, 1'b0);

    issue("err_lw_22", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
    issue("err_sh_23", 1'b1, SZ_H, 1'b0, 32'h23, 32'h0000_FFFF, 32'h0, 1'b1);
    issue("err_lw_1000", 1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    issue("err_size11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
    issue("err_sw_1020", 1'b1, SZ_W, 1'b0, 32'h1020, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue("lw_20_c", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h5566_CC44, 1'b0);
    idle();
    drain("basic");

    issue("b2b_0", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8899_AABB, 1'b0);
    issue("b2b_1", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h5566_CC44, 1'b0);
    issue("b2b_2", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h0000_00AA, 1'b0);
    issue("b2b_3", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0);
    issue("b2b_4", 1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 32'h0000_5566, 1'b0);
    issue("b2b_5", 1'b0, SZ_H, 1'b0, 32'h20, 32'h0, 32'hFFFF_CC44, 1'b0);
    issue("b2b_6", 1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 32'hFFFF_FFCC, 1'b0);
    issue("b2b_7", 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
    idle();
    drain("b2b");

    issue("sw_ffc", 1'b1, SZ_W, 1'b0, 32'hFFC, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue("lw_ffc", 1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    clear              = 1'b1;
    bus_i.req_valid    = 1'b1;
    bus_i.req_we       = 1'b0;
    bus_i.req_size     = SZ_W;
    bus_i.req_addr     = 32'h10;
    #1;
    check("clear_wins_ready", 32'(bus_i.req_ready), 32'd0);
    @(negedge clk);
    clear           = 1'b0;
    bus_i.req_valid = 1'b0;
    #1;
    check("clear_busy", 32'(busy), 32'd1);
    repeat (500) @(negedge clk);
    check("clear_drained", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    #1;
    check("midsweep_rst_busy", 32'(busy), 32'd1);
    check("midsweep_rst_ready", 32'(bus_i.req_ready), 32'd0);
    check("midsweep_rst_valid", 32'(bus_i.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sweep_wait("restart_sweep");
    issue("z_lw_ffc", 1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0);
    issue("z_lw_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    issue("z_lw_20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    idle();
    drain("zeroed");

    issue("discard_lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    bus_i.req_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        #1;
        if (bus_i.resp_valid !== 1'b0) seen++;
        @(negedge clk);
      end
      check("discard_no_resp", 32'(seen), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
